cache_ctrl: RTL and testbench

- Sequencing controller for a 4-line, fully associative, write-through cache in front of the 8-bit-address word RAM.
- Accepts one CPU request at a time: tag compare, LRU update, line fill on read miss, write-through to RAM on every write.
- Holds the tag, data, valid and LRU-age arrays internally. The RAM is reached through a simple request/acknowledge port.

---
 rtl/cache_ctrl.sv | 174 +++++++++++++++++
 tb/tb_cache_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl: sequencing controller for a 4-line fully associative write-through cache
//
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-low reset
//   enab       CPU request strobe, sampled only in IDLE
//   rw         1 = write, 0 = read
//   addr       request address (full address is the tag)
//   data       write data
//   data_out   read data, valid while done=1, held afterwards
//   hit        lookup result of the completed request, valid while done=1
//   busy       high from capture until the DONE cycle ends
//   done       one-cycle completion pulse
//   mem_enab   RAM request, held until mem_ack
//   mem_rw     1 = RAM write
//   mem_addr   RAM address
//   mem_wdata  RAM write data
//   mem_rdata  RAM read data, valid with mem_ack
//   mem_ack    RAM completion pulse
//   state      current FSM encoding (debug)
//   hit_cnt    saturating hit counter     (only with CACHE_STATS_EN)
//   miss_cnt   saturating miss counter    (only with CACHE_STATS_EN)
//
// Optional feature macro: CACHE_STATS_EN
module cache_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              enab,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] data_out,
    output logic              hit,
    output logic              busy,
    output logic              done,
    output logic              mem_enab,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [3:0]        state
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);
    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] LOOKUP = 4'd1;
    localparam logic [3:0] MEM_RD = 4'd2;
    localparam logic [3:0] MEM_WR = 4'd3;
    localparam logic [3:0] DONE   = 4'd4;

    logic [3:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdat_q;
    logic              rw_q;
    logic [ADDR_W-1:0] tag_q [4];
    logic [DATA_W-1:0] line_q [4];
    logic [3:0]        vld_q;
    logic [1:0]        age_q [4];
    logic [1:0]        age_d [4];
    logic [DATA_W-1:0] dout_q;
    logic              hit_q;
    logic              hit_any;
    logic [1:0]        hit_idx;
    logic [1:0]        vic;
    logic [1:0]        tidx;
    logic              touch;

    // Tag match plus victim choice: the descending scan lets the lowest
    // invalid line override the age-3 line.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = 2'd0;
        vic     = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (vld_q[i] && tag_q[i] == addr_q) begin
                hit_any = 1'b1;
                hit_idx = 2'(i);
            end
            if (age_q[i] == 2'd3) vic = 2'(i);
        end
        for (int i = 3; i >= 0; i--) if (!vld_q[i]) vic = 2'(i);
    end

    // LRU touch: lines younger than the touched one age by one, touched line becomes 0.
    always_comb begin
        tidx  = state_q == LOOKUP ? hit_idx : vic;
        touch = (state_q == LOOKUP && hit_any) || (state_q == MEM_RD && mem_ack);
        for (int i = 0; i < 4; i++)
            age_d[i] = 2'(i) == tidx ? 2'd0 : age_q[i] < age_q[tidx] ? age_q[i] + 2'd1 : age_q[i];
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE   ? (enab ? LOOKUP : IDLE) :
                  state_q == LOOKUP ? (rw_q ? MEM_WR : hit_any ? DONE : MEM_RD) :
                  (state_q == MEM_RD || state_q == MEM_WR) ? (mem_ack ? DONE : state_q) :
                  IDLE;
    end

    // RAM port fields are forced to zero outside a transaction so reset clears them at once.
    always_comb begin
        busy      = state_q != IDLE;
        done      = state_q == DONE;
        mem_enab  = state_q == MEM_RD || state_q == MEM_WR;
        mem_rw    = state_q == MEM_WR;
        mem_addr  = mem_enab ? addr_q : '0;
        mem_wdata = mem_rw ? wdat_q : '0;
        data_out  = dout_q;
        hit       = hit_q;
        state     = state_q;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            addr_q <= '0;
            wdat_q <= '0;
            rw_q   <= 1'b0;
            vld_q  <= '0;
            dout_q <= '0;
            hit_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                tag_q[i]  <= '0;
                line_q[i] <= '0;
                age_q[i]  <= 2'(i);
            end
        end else begin
            if (state_q == IDLE && enab) begin
                addr_q <= addr;
                wdat_q <= data;
                rw_q   <= rw;
            end
            if (state_q == LOOKUP) begin
                hit_q <= hit_any;
                if (hit_any && rw_q) line_q[hit_idx] <= wdat_q;
                if (hit_any && !rw_q) dout_q <= line_q[hit_idx];
            end
            if (state_q == MEM_RD && mem_ack) begin
                tag_q[vic]  <= addr_q;
                line_q[vic] <= mem_rdata;
                vld_q[vic]  <= 1'b1;
                dout_q      <= mem_rdata;
            end
            if (touch) for (int i = 0; i < 4; i++) age_q[i] <= age_d[i];
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == DONE) begin
            if (hit_q && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            if (!hit_q && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: scoreboard bench for cache_ctrl against an LRU-list reference model
module tb_cache_ctrl;
    logic       clk, clr, enab, rw;
    logic [7:0] addr, data, data_out, mem_addr, mem_wdata, mem_rdata;
    logic       hit, busy, done, mem_enab, mem_rw, mem_ack;
    logic [3:0] state;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    cache_ctrl dut (
        .clk(clk), .clr(clr), .enab(enab), .rw(rw), .addr(addr), .data(data),
        .data_out(data_out), .hit(hit), .busy(busy), .done(done),
        .mem_enab(mem_enab), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .state(state)
`ifdef CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    typedef struct {logic w; logic h; logic [7:0] a; logic [7:0] d; int cap;} exp_t;
    typedef struct {logic w; logic [7:0] a; logic [7:0] d;} mem_t;

    exp_t       expq[$];
    mem_t       memq[$];
    logic [7:0] lru[$];
    logic [7:0] ram[256];
    logic [7:0] model_mem[256];
    int tests = 0, fails = 0, cyc = 0, hcnt = 0, mcnt = 0, fix_dly = -1;
    bit stray = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int find(input logic [7:0] a);
        foreach (lru[i]) if (lru[i] == a) return i;
        return -1;
    endfunction

    // RAM responder: fixed or random ack latency, optional stray acks while idle.
    initial begin
        int  wcnt = 0;
        bit  seen = 0;
        mem_ack   = 0;
        mem_rdata = 0;
        forever begin
            @(negedge clk);
            mem_ack = 0;
            if (mem_enab) begin
                if (!seen) begin
                    seen = 1;
                    wcnt = fix_dly >= 0 ? fix_dly : int'($urandom_range(0, 3));
                end
                if (wcnt == 0) begin
                    mem_ack   = 1;
                    mem_rdata = ram[mem_addr];
                    if (mem_rw) ram[mem_addr] = mem_wdata;
                    seen = 0;
                end else wcnt--;
            end else begin
                seen = 0;
                if (stray && $urandom_range(0, 5) == 0) begin
                    mem_ack   = 1;
                    mem_rdata = 8'($urandom);
                end
            end
        end
    end

    // Monitor: checks RAM requests and completions against the queued expectations.
    initial begin
        logic men_prev = 0;
        exp_t e;
        mem_t m;
        forever begin
            @(negedge clk);
            if (mem_enab && !men_prev) begin
                if (memq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL mem_unexpected: got request rw=%0b addr=%0h expected none", mem_rw, mem_addr);
                end else begin
                    m = memq.pop_front();
                    chk("mem_rw", mem_rw, m.w);
                    chk("mem_addr", mem_addr, m.a);
                    if (m.w) chk("mem_wdata", mem_wdata, m.d);
                end
            end
            men_prev = mem_enab;
            if (done) begin
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL done_unexpected: got done expected none");
                end else begin
                    e = expq.pop_front();
                    chk("hit", hit, e.h);
                    if (!e.w) chk("data_out", data_out, e.d);
                    if (!e.w && e.h) chk("hit_latency", cyc - e.cap, 2);
                    chk("mem_pending", memq.size(), 0);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            tests++;
            fails++;
            $display("FAIL timeout: busy still %0b expected 0", busy);
        end
    endtask

    // Issue one request at a negedge; want >= 0 pins the expected hit flag.
    task automatic req(input logic w, input logic [7:0] a, input logic [7:0] d, input int want);
        int   i;
        logic h;
        exp_t e;
        wait_idle();
        i = find(a);
        h = want >= 0 ? want[0] : logic'(i >= 0);
        if (i >= 0) begin
            lru.delete(i);
            lru.push_front(a);
        end else if (!w) begin
            lru.push_front(a);
            if (lru.size() > 4) lru.delete(4);
        end
        if (w) model_mem[a] = d;
        if (h) hcnt++;
        else mcnt++;
        if (w || !h) memq.push_back('{w, a, d});
        e = '{w, h, a, model_mem[a], cyc};
        expq.push_back(e);
        enab = 1;
        rw   = w;
        addr = a;
        data = d;
        @(negedge clk);
        enab = 0;
        rw   = 1'($urandom);
        addr = 8'($urandom);
        data = 8'($urandom);
        wait_idle();
    endtask

    initial begin
        clr  = 0;
        enab = 0;
        rw   = 0;
        addr = 0;
        data = 0;
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        ram[8'h00] = 8'h80;
        ram[8'h02] = 8'h3C;
        model_mem  = ram;
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hit", hit, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_mem_enab", mem_enab, 0);
        chk("rst_mem_rw", mem_rw, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        clr = 1;
        @(negedge clk);

        fix_dly = 3;
        req(0, 8'h00, 0, 0);
        fix_dly = -1;
        req(0, 8'h00, 0, 1);
`ifdef CACHE_STATS_EN
        chk("hit_cnt_dir", hit_cnt, 1);
        chk("miss_cnt_dir", miss_cnt, 1);
`endif
        req(1, 8'h02, 8'hC0, 0);
        req(0, 8'h02, 0, 0);
        req(0, 8'h10, 0, 0);
        req(0, 8'h11, 0, 0);
        req(0, 8'h12, 0, 0);
        req(0, 8'h13, 0, 0);
        req(0, 8'h10, 0, 1);
        req(0, 8'h14, 0, 0);
        req(0, 8'h11, 0, 0);
        req(0, 8'h10, 0, 1);
        req(0, 8'hFF, 0, 0);
        req(1, 8'hFF, 8'h5A, 1);
        req(0, 8'hFF, 0, 1);

        stray = 1;
        for (int k = 0; k < 200; k++) begin
            int r = $urandom_range(0, 9);
            req(logic'($urandom_range(0, 2) == 0), r == 8 ? 8'hFF : r == 9 ? 8'hFE : 8'(r),
                8'($urandom), -1);
        end
        stray = 0;

        wait_idle();
        fix_dly = 30;
        memq.push_back('{1'b0, 8'h55, 8'h00});
        enab = 1;
        rw   = 0;
        addr = 8'h55;
        @(negedge clk);
        enab = 0;
        for (int n = 0; n < 10 && !mem_enab; n++) @(negedge clk);
        chk("mem_enab_before_clr", mem_enab, 1);
        #2 clr = 0;
        #1;
        chk("clr_mem_enab", mem_enab, 0);
        chk("clr_busy", busy, 0);
        chk("clr_done", done, 0);
        chk("clr_state", state, 0);
        expq.delete();
        memq.delete();
        lru.delete();
        hcnt = 0;
        mcnt = 0;
        @(negedge clk);
        clr     = 1;
        fix_dly = -1;
        @(negedge clk);
        req(0, 8'h55, 0, 0);
        req(0, 8'h55, 0, 1);

        repeat (4) @(negedge clk);
        chk("expq_drained", expq.size(), 0);
`ifdef CACHE_STATS_EN
        chk("hit_cnt_final", hit_cnt, hcnt);
        chk("miss_cnt_final", miss_cnt, mcnt);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
